// File: rtl/div_pkg.sv
// Shared types and constants for the parametrised iterative divider.
// Sizes here cover the widest supported XLEN; the divider narrows them with casts.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int MAX_XLEN = 64;
    localparam int CNT_W    = $clog2(MAX_XLEN / 1);

    localparam logic [MAX_XLEN-1:0] DIV0_QUOT = {MAX_XLEN{1'b1}};
    localparam logic [MAX_XLEN-1:0] OVF_REM   = {MAX_XLEN{1'b0}};

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_iter_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] partial,
    input  logic [W-1:0] divisor,
    input  logic         dvd_bit,
    output logic [W-1:0] rem_next,
    output logic         quot_bit
);

    logic [W:0] shifted_s;
    logic [W:0] diff_s;

    // Trial subtraction; partial < divisor keeps shifted below 2*divisor
    always_comb begin
        shifted_s = {partial, dvd_bit};
        diff_s    = shifted_s - {1'b0, divisor};
        if (shifted_s >= {1'b0, divisor}) begin
            quot_bit = 1'b1;
            rem_next = diff_s[W-1:0];
        end else begin
            quot_bit = 1'b0;
            rem_next = shifted_s[W-1:0];
        end
    end

endmodule

// File: rtl/multi_cycle_div_param.sv
// Iterative RISC-V M divider (DIV/DIVU/REM/REMU and W forms) with
// configurable width and quotient bits per cycle, valid/ready handshakes and flush.
module multi_cycle_div_param
    import div_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 1,
    parameter int HAS_WORD       = 1,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_signed_i,
    input  logic             req_word_i,
    input  logic [XLEN-1:0]  req_dividend_i,
    input  logic [XLEN-1:0]  req_divisor_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  resp_quot_o,
    output logic [XLEN-1:0]  resp_rem_o,
    output logic [TAG_W-1:0] resp_tag_o
);

    localparam int              B        = BITS_PER_CYCLE;
    localparam logic            WORD_OK  = (HAS_WORD != 0) && (XLEN == 64);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN / B - 1);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32 / B - 1);
    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD = {XLEN{1'b1}} << 6'd31;

    if ((32 % BITS_PER_CYCLE) != 0) begin : g_bpc_check
        $error("BITS_PER_CYCLE must divide 32");
    end

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        return ({XLEN{x[31]}} << 6'd32) | XLEN'(x[31:0]);
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
        return XLEN'(x[31:0]);
    endfunction

    div_state_e       state_r, state_next_s;
    logic             req_ready_r, resp_valid_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  dvd_r, dsr_r, quot_r, rem_r;
    logic             neg_q_r, neg_rem_r, word_r;
    logic [TAG_W-1:0] tag_r;
    logic [XLEN-1:0]  resp_quot_r, resp_rem_r;
    logic [TAG_W-1:0] resp_tag_r;

    logic             accept_s, word_s, a_neg_s, b_neg_s, div0_s, ovf_s, special_s;
    logic [XLEN-1:0]  a_ext_s, b_ext_s, a_mag_s, b_mag_s, dvd_align_s;
    logic [XLEN-1:0]  spec_quot_s, spec_rem_s, q_signed_s, r_signed_s, fix_quot_s, fix_rem_s;
    logic [XLEN-1:0]  step_rem_s;
    logic [B-1:0]     qbits_s;

    // Request decode: op-width extension, magnitudes and special-case detection
    always_comb begin
        accept_s = req_valid_i && req_ready_r && !flush_i;
        word_s   = WORD_OK && req_word_i;
        if (word_s) begin
            a_ext_s = req_signed_i ? sext32(req_dividend_i) : zext32(req_dividend_i);
            b_ext_s = req_signed_i ? sext32(req_divisor_i)  : zext32(req_divisor_i);
        end else begin
            a_ext_s = req_dividend_i;
            b_ext_s = req_divisor_i;
        end
        a_neg_s     = req_signed_i && a_ext_s[XLEN-1];
        b_neg_s     = req_signed_i && b_ext_s[XLEN-1];
        a_mag_s     = a_neg_s ? -a_ext_s : a_ext_s;
        b_mag_s     = b_neg_s ? -b_ext_s : b_ext_s;
        dvd_align_s = word_s ? (a_mag_s << (XLEN - 32)) : a_mag_s;
        div0_s      = (b_ext_s == {XLEN{1'b0}});
        ovf_s       = req_signed_i && (b_ext_s == {XLEN{1'b1}}) &&
                      (a_ext_s == (word_s ? MIN_WORD : MIN_FULL));
        special_s   = div0_s || ovf_s;
        if (div0_s) begin
            spec_quot_s = XLEN'(DIV0_QUOT);
            spec_rem_s  = word_s ? sext32(a_ext_s) : a_ext_s;
        end else begin
            spec_quot_s = a_ext_s;
            spec_rem_s  = XLEN'(OVF_REM);
        end
    end

    // Sign fix-up of the unsigned quotient/remainder, word results widened from bit 31
    always_comb begin
        q_signed_s = neg_q_r   ? -quot_r : quot_r;
        r_signed_s = neg_rem_r ? -rem_r  : rem_r;
        fix_quot_s = word_r ? sext32(q_signed_s) : q_signed_s;
        fix_rem_s  = word_r ? sext32(r_signed_s) : r_signed_s;
    end

    for (genvar i = 0; i < B; i++) begin : g_step
        logic [XLEN-1:0] rem_in_s;
        logic [XLEN-1:0] rem_out_s;
        if (i == 0) begin : g_head
            assign rem_in_s = rem_r;
        end else begin : g_link
            assign rem_in_s = g_step[i-1].rem_out_s;
        end
        div_iter_step #(.W(XLEN)) u_step (
            .partial  (rem_in_s),
            .divisor  (dsr_r),
            .dvd_bit  (dvd_r[XLEN-1-i]),
            .rem_next (rem_out_s),
            .quot_bit (qbits_s[B-1-i])
        );
    end
    assign step_rem_s = g_step[B-1].rem_out_s;

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_next_s = state_r;
        if (flush_i) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = accept_s ? (special_s ? DONE : CALC) : IDLE;
                CALC:    state_next_s = (cnt_r == {CNT_W{1'b0}}) ? FIX : CALC;
                FIX:     state_next_s = DONE;
                DONE:    state_next_s = resp_ready_i ? IDLE : DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register with handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            req_ready_r  <= (state_next_s == IDLE);
            resp_valid_r <= (state_next_s == DONE);
        end
    end

    // Iteration datapath: operand capture on accept, shift/subtract while calculating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            dvd_r     <= {XLEN{1'b0}};
            dsr_r     <= {XLEN{1'b0}};
            quot_r    <= {XLEN{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            word_r    <= 1'b0;
            tag_r     <= {TAG_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r     <= word_s ? CNT_WORD : CNT_FULL;
                        dvd_r     <= dvd_align_s;
                        dsr_r     <= b_mag_s;
                        quot_r    <= {XLEN{1'b0}};
                        rem_r     <= {XLEN{1'b0}};
                        neg_q_r   <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= a_neg_s;
                        word_r    <= word_s;
                        tag_r     <= req_tag_i;
                    end
                end
                CALC: begin
                    cnt_r  <= cnt_r - CNT_W'(1);
                    dvd_r  <= dvd_r << B;
                    quot_r <= (quot_r << B) | XLEN'(qbits_s);
                    rem_r  <= step_rem_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Response registers, loaded only on entry to DONE so they hold under back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_quot_r <= {XLEN{1'b0}};
            resp_rem_r  <= {XLEN{1'b0}};
            resp_tag_r  <= {TAG_W{1'b0}};
        end else if (state_r == IDLE && state_next_s == DONE) begin
            resp_quot_r <= spec_quot_s;
            resp_rem_r  <= spec_rem_s;
            resp_tag_r  <= req_tag_i;
        end else if (state_r == FIX && state_next_s == DONE) begin
            resp_quot_r <= fix_quot_s;
            resp_rem_r  <= fix_rem_s;
            resp_tag_r  <= tag_r;
        end
    end

    assign req_ready_o  = req_ready_r;
    assign resp_valid_o = resp_valid_r;
    assign resp_quot_o  = resp_quot_r;
    assign resp_rem_o   = resp_rem_r;
    assign resp_tag_o   = resp_tag_r;

endmodule

// File: tb/tb_multi_cycle_div_param.sv
// Self-checking bench: directed and random divisions on a 1-bit and a 4-bit-per-cycle
// divider, compared against a plain-arithmetic RISC-V division model.
module tb_multi_cycle_div_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_signed = 1'b0;
    logic        req_word = 1'b0;
    logic        resp_ready = 1'b0;
    logic [63:0] dividend = 64'd0;
    logic [63:0] divisor = 64'd0;
    logic [3:0]  tag = 4'd0;
    int          sel = 0;

    logic        rdy0, rdy1, vld0, vld1;
    logic [63:0] q0, q1, r0, r1;
    logic [3:0]  t0, t1;
    logic        rdy, vld;
    logic [63:0] q, r;
    logic [3:0]  t;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multi_cycle_div_param #(.XLEN(64), .BITS_PER_CYCLE(1), .HAS_WORD(1), .TAG_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .req_valid_i(req_valid && (sel == 0)), .req_ready_o(rdy0),
        .req_signed_i(req_signed), .req_word_i(req_word),
        .req_dividend_i(dividend), .req_divisor_i(divisor), .req_tag_i(tag),
        .resp_valid_o(vld0), .resp_ready_i(resp_ready),
        .resp_quot_o(q0), .resp_rem_o(r0), .resp_tag_o(t0)
    );

    multi_cycle_div_param #(.XLEN(64), .BITS_PER_CYCLE(4), .HAS_WORD(1), .TAG_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .req_valid_i(req_valid && (sel == 1)), .req_ready_o(rdy1),
        .req_signed_i(req_signed), .req_word_i(req_word),
        .req_dividend_i(dividend), .req_divisor_i(divisor), .req_tag_i(tag),
        .resp_valid_o(vld1), .resp_ready_i(resp_ready),
        .resp_quot_o(q1), .resp_rem_o(r1), .resp_tag_o(t1)
    );

    assign rdy = (sel == 0) ? rdy0 : rdy1;
    assign vld = (sel == 0) ? vld0 : vld1;
    assign q   = (sel == 0) ? q0 : q1;
    assign r   = (sel == 0) ? r0 : r1;
    assign t   = (sel == 0) ? t0 : t1;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
        end
    endtask

    // RISC-V M division semantics written with ordinary integer operators
    function automatic void ref_div(input bit sgn, input bit word, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] eq,
                                    output logic [63:0] er, output bit special);
        logic [31:0] a32, b32, q32, r32;
        if (word) begin
            a32 = a[31:0];
            b32 = b[31:0];
            special = (b32 == 32'd0) || (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = a32;
            end else if (special) begin
                q32 = a32;
                r32 = 32'd0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            eq = {{32{q32[31]}}, q32};
            er = {{32{r32[31]}}, r32};
        end else begin
            special = (b == 64'd0) || (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
            if (b == 64'd0) begin
                eq = 64'hFFFF_FFFF_FFFF_FFFF;
                er = a;
            end else if (special) begin
                eq = a;
                er = 64'd0;
            end else if (sgn) begin
                eq = $signed(a) / $signed(b);
                er = $signed(a) % $signed(b);
            end else begin
                eq = a / b;
                er = a % b;
            end
        end
    endfunction

    task automatic run_op(input bit sgn, input bit word, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] tg, input int hold);
        logic [63:0] eq, er;
        bit          special;
        int          cyc, exp_lat, bpc;
        ref_div(sgn, word, a, b, eq, er, special);
        bpc     = (sel == 0) ? 1 : 4;
        exp_lat = special ? 1 : ((word ? 32 : 64) / bpc + 2);
        cyc = 0;
        while (!rdy && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("ready_before_req", 64'(rdy), 64'd1);
        req_valid = 1'b1; req_signed = sgn; req_word = word;
        dividend = a; divisor = b; tag = tg;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!vld && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("latency", 64'(cyc), 64'(exp_lat));
        check_eq("quot", q, eq);
        check_eq("rem", r, er);
        check_eq("tag", 64'(t), 64'(tg));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(vld), 64'd1);
            check_eq("hold_quot", q, eq);
            check_eq("hold_rem", r, er);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("valid_after_hs", 64'(vld), 64'd0);
        check_eq("ready_after_hs", 64'(rdy), 64'd1);
    endtask

    task automatic watch_no_resp(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (vld) seen++;
        end
        check_eq(name, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] a, b;
        bit          sgn, word;
        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(rdy0), 64'd1);
        check_eq("rst_valid", 64'(vld0), 64'd0);
        check_eq("rst_quot", q0, 64'd0);
        check_eq("rst_rem", r0, 64'd0);
        check_eq("rst_tag", 64'(t0), 64'd0);
        check_eq("rst_ready_b4", 64'(rdy1), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        sel = 0;
        run_op(1'b0, 1'b0, 64'd100, 64'd7, 4'd3, 5);
        run_op(1'b1, 1'b0, -64'sd7, 64'd2, 4'd5, 0);
        run_op(1'b1, 1'b0, 64'd7, -64'sd2, 4'd6, 1);
        run_op(1'b0, 1'b0, 64'h1234, 64'd0, 4'd7, 2);
        run_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 0);
        run_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 4'd9, 0);
        run_op(1'b0, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3, 4'd10, 0);
        sel = 1;
        run_op(1'b0, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3, 4'd11, 0);
        run_op(1'b1, 1'b0, -64'sd1000, 64'd33, 4'd12, 1);

        // flush in the tenth calculation cycle
        sel = 0;
        req_valid = 1'b1; req_signed = 1'b0; req_word = 1'b0;
        dividend = 64'd100; divisor = 64'd7; tag = 4'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_ready", 64'(rdy), 64'd1);
        check_eq("flush_valid", 64'(vld), 64'd0);
        watch_no_resp("flush_no_resp", 80);

        // flush together with a request in IDLE drops the request
        req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        check_eq("flush_req_ready", 64'(rdy), 64'd1);
        watch_no_resp("flush_req_no_resp", 80);

        // randomized operations on both configurations
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int n = 0; n < 25; n++) begin
                sgn  = 1'($urandom_range(0, 1));
                word = 1'($urandom_range(0, 1));
                a = {$urandom(), $urandom()};
                b = {$urandom(), $urandom()};
                case ($urandom_range(0, 5))
                    0: b = 64'($urandom_range(1, 20));
                    1: b = 64'd0;
                    2: begin
                        a = word ? 64'h1234_5678_8000_0000 : 64'h8000_0000_0000_0000;
                        b = 64'hFFFF_FFFF_FFFF_FFFF;
                    end
                    3: b = 64'hFFFF_FFFF_FFFF_FFFF;
                    4: b = b >> $urandom_range(0, 60);
                    default: begin end
                endcase
                run_op(sgn, word, a, b, 4'($urandom()), $urandom_range(0, 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
